// File: rtl/serial_word_tx.sv
// Serial word transmitter: shifts an Nbits word out MSB first behind an active-low select.
// First dclk_o rise Div+1 cycles after start; starts arriving while busy are dropped.
module serial_word_tx #(
  parameter int Nbits = 24,
  parameter int Div   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Nbits-1:0] data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             cs_o,
  output logic             dclk_o,
  output logic             sdo_o
);

  localparam int CW = (Div > 1) ? $clog2(Div) : 1;
  localparam int BW = $clog2(Nbits + 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [Nbits-1:0] shreg_q, shreg_d;
  logic             done_q, done_d;
  logic             last_cyc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    last_cyc  = (cnt_q == CW'(Div - 1));

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          shreg_d   = data_i;
          bit_cnt_d = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (last_cyc) state_d = HIGH;
      end
      HIGH: begin
        if (last_cyc) begin
          state_d   = LOW;
          shreg_d   = {shreg_q[Nbits-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      LOW: begin
        if (last_cyc) begin
          if (bit_cnt_q < BW'(Nbits)) begin
            state_d = HIGH;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Half-period counter restarts at every phase boundary.
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      done_q    <= done_d;
    end
  end

  // All outputs decode registered state only.
  assign busy_o = (state_q != IDLE);
  assign cs_o   = (state_q == IDLE);
  assign dclk_o = (state_q == HIGH);
  assign sdo_o  = (state_q != IDLE) && shreg_q[Nbits-1];
  assign done_o = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx at three parameter sets: (24,4), (24,1), (2,3).
module tb_serial_word_tx;

  logic clk;
  logic rst;

  logic        start0, start1, start2;
  logic [23:0] data0, data1;
  logic [1:0]  data2;
  logic        busy0, done0, cs0, dclk0, sdo0;
  logic        busy1, done1, cs1, dclk1, sdo1;
  logic        busy2, done2, cs2, dclk2, sdo2;

  int n_total;
  int n_bad;

  serial_word_tx #(.Nbits(24), .Div(4)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .data_i(data0),
    .busy_o(busy0), .done_o(done0), .cs_o(cs0), .dclk_o(dclk0), .sdo_o(sdo0)
  );
  serial_word_tx #(.Nbits(24), .Div(1)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .data_i(data1),
    .busy_o(busy1), .done_o(done1), .cs_o(cs1), .dclk_o(dclk1), .sdo_o(sdo1)
  );
  serial_word_tx #(.Nbits(2), .Div(3)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .data_i(data2),
    .busy_o(busy2), .done_o(done2), .cs_o(cs2), .dclk_o(dclk2), .sdo_o(sdo2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Receiver model: samples sdo on every dclk rise, counts busy and done cycles.
  logic [23:0] cap0, cap1;
  logic [1:0]  cap2;
  int edges0, edges1, edges2, edges_cs_hi;
  int busyc0, busyc1, busyc2;
  int donec0, donec1, donec2;
  logic pd0, pd1, pd2;

  initial begin
    pd0 = 1'b0; pd1 = 1'b0; pd2 = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (dclk0 && !pd0) begin
      cap0 = {cap0[22:0], sdo0};
      edges0++;
      if (cs0) edges_cs_hi++;
    end
    if (dclk1 && !pd1) begin
      cap1 = {cap1[22:0], sdo1};
      edges1++;
      if (cs1) edges_cs_hi++;
    end
    if (dclk2 && !pd2) begin
      cap2 = {cap2[0], sdo2};
      edges2++;
      if (cs2) edges_cs_hi++;
    end
    if (busy0) busyc0++;
    if (busy1) busyc1++;
    if (busy2) busyc2++;
    if (done0) donec0++;
    if (done1) donec1++;
    if (done2) donec2++;
    pd0 = dclk0;
    pd1 = dclk1;
    pd2 = dclk2;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    cap0 = '0; cap1 = '0; cap2 = '0;
    edges0 = 0; edges1 = 0; edges2 = 0; edges_cs_hi = 0;
    busyc0 = 0; busyc1 = 0; busyc2 = 0;
    donec0 = 0; donec1 = 0; donec2 = 0;
  endtask

  task automatic wait_done(input int which, input int budget, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      case (which)
        0: seen = (donec0 > 0) ? 1 : 0;
        1: seen = (donec1 > 0) ? 1 : 0;
        default: seen = (donec2 > 0) ? 1 : 0;
      endcase
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    int seen;
    n_total = 0;
    n_bad = 0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    data0 = '0; data1 = '0; data2 = '0;
    clr_mon();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_cs", cs0, 1);
    chk("rst_dclk", dclk0, 0);
    chk("rst_sdo", sdo0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_cs_u2", cs2, 1);
    repeat (3) @(negedge clk);

    // Basic frame; start presented with reset release, so the first edge must take it.
    rst = 1'b1;
    start0 = 1'b1;
    data0 = 24'hA5C33C;
    clr_mon();
    @(negedge clk);
    start0 = 1'b0;
    data0 = 24'h000000;
    chk("first_start_busy", busy0, 1);
    chk("setup_cs", cs0, 0);
    chk("setup_dclk", dclk0, 0);
    chk("setup_sdo_msb", sdo0, 1);
    wait_done(0, 400, "basic_timeout");
    chk("basic_word", cap0, 24'hA5C33C);
    chk("basic_edges", edges0, 24);
    chk("basic_busy", busyc0, 196);
    chk("basic_done_cs", cs0, 1);
    chk("edges_cs_high", edges_cs_hi, 0);
    @(negedge clk);
    chk("basic_done_cnt", donec0, 1);
    chk("basic_idle_sdo", sdo0, 0);

    // Div=1 timing: dclk rises two cycles after the start cycle.
    start1 = 1'b1;
    data1 = 24'h000001;
    clr_mon();
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    chk("div1_cyc1_dclk", dclk1, 0);
    @(negedge clk);
    chk("div1_cyc2_dclk", dclk1, 1);
    wait_done(1, 200, "div1_timeout");
    chk("div1_word", cap1, 24'h000001);
    chk("div1_edges", edges1, 24);
    chk("div1_busy", busyc1, 49);

    // Starts while busy are ignored, as are data changes.
    @(negedge clk);
    start0 = 1'b1;
    data0 = 24'h5A0F96;
    clr_mon();
    @(negedge clk);
    start0 = 1'b0;
    data0 = 24'hFFFFFF;
    repeat (9) @(negedge clk);
    start0 = 1'b1;
    data0 = 24'h123456;
    @(negedge clk);
    start0 = 1'b0;
    data0 = 24'h0;
    repeat (89) @(negedge clk);
    start0 = 1'b1;
    data0 = 24'hFFFFFF;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, 400, "busy_timeout");
    chk("busy_word", cap0, 24'h5A0F96);
    chk("busy_busy", busyc0, 196);
    repeat (20) @(negedge clk);
    chk("busy_done_cnt", donec0, 1);
    chk("busy_no_restart", busy0, 0);

    // Back-to-back: start held during the done cycle.
    start0 = 1'b1;
    data0 = 24'h0F0F0F;
    clr_mon();
    @(negedge clk);
    start0 = 1'b0;
    seen = 0;
    for (int i = 0; i < 400 && seen == 0; i++) begin
      @(negedge clk);
      if (done0) seen = 1;
    end
    chk("b2b_first_done", seen, 1);
    chk("b2b_first_word", cap0, 24'h0F0F0F);
    chk("b2b_done_cs", cs0, 1);
    start0 = 1'b1;
    data0 = 24'hFFFFFF;
    clr_mon();
    @(negedge clk);
    start0 = 1'b0;
    data0 = 24'h0;
    chk("b2b_cs_one_cycle", cs0, 0);
    wait_done(0, 400, "b2b_timeout");
    chk("b2b_word", cap0, 24'hFFFFFF);
    chk("b2b_edges", edges0, 24);

    // Mid-frame reset after the 10th dclk rise.
    @(negedge clk);
    start0 = 1'b1;
    data0 = 24'h3C3C3C;
    clr_mon();
    @(negedge clk);
    start0 = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge clk);
      if (edges0 >= 10) seen = 1;
    end
    chk("mid_reach_edge10", seen, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_cs", cs0, 1);
    chk("mid_rst_dclk", dclk0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_sdo", sdo0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_no_done", donec0, 0);
    chk("mid_idle_after", busy0, 0);
    start0 = 1'b1;
    data0 = 24'hC0FFEE;
    clr_mon();
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, 400, "mid_next_timeout");
    chk("mid_next_word", cap0, 24'hC0FFEE);
    chk("mid_next_edges", edges0, 24);

    // Minimum width: Nbits=2, Div=3.
    @(negedge clk);
    start2 = 1'b1;
    data2 = 2'b10;
    clr_mon();
    @(negedge clk);
    start2 = 1'b0;
    data2 = 2'b01;
    wait_done(2, 100, "edge_timeout");
    chk("edge_edges", edges2, 2);
    chk("edge_word", cap2, 2'b10);
    chk("edge_busy", busyc2, 15);
    @(negedge clk);
    chk("edge_done_cnt", donec2, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
